// File: rtl/reservation_station.sv
// Per-class reservation station: holds issued instructions until both operands are ready, then dispatches one per cycle.
// Ready-at-arrival reaches o_out_valid two cycles later; the output register and all entries hold while o_out_valid && !i_out_ready.
module reservation_station #(
  parameter int         XLEN    = 32,
  parameter int         SIZE    = 8,
  parameter int         TAG_W   = 5,
  parameter logic [2:0] ST_TYPE = 3'd0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic [1:0]                 i_in_valid,
  input  logic [1:0][2:0]            i_in_st_type,
  input  logic [1:0][7:0]            i_in_instr,
  input  logic [1:0][XLEN-1:0]       i_in_address,
  input  logic [1:0][XLEN-1:0]       i_in_immediate,
  input  logic [1:0][TAG_W-1:0]      i_in_src1_tag,
  input  logic [1:0][TAG_W-1:0]      i_in_src2_tag,
  input  logic [1:0][XLEN-1:0]       i_in_src1_val,
  input  logic [1:0][XLEN-1:0]       i_in_src2_val,
  input  logic [1:0]                 i_in_src1_rdy,
  input  logic [1:0]                 i_in_src2_rdy,
  input  logic [1:0][TAG_W-1:0]      i_in_dst_tag,
  input  logic [1:0]                 i_cdb_valid,
  input  logic [1:0][TAG_W-1:0]      i_cdb_tag,
  input  logic [1:0][XLEN-1:0]       i_cdb_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [7:0]                 o_out_instr,
  output logic [XLEN-1:0]            o_out_address,
  output logic [XLEN-1:0]            o_out_immediate,
  output logic [XLEN-1:0]            o_out_src1,
  output logic [XLEN-1:0]            o_out_src2,
  output logic [TAG_W-1:0]           o_out_dst_tag,
  output logic                       o_full,
  output logic                       o_overflow
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE + 1);

  typedef struct packed {
    logic [7:0]       instr;
    logic [XLEN-1:0]  address;
    logic [XLEN-1:0]  immediate;
    logic             s1_rdy;
    logic [TAG_W-1:0] s1_tag;
    logic [XLEN-1:0]  s1_val;
    logic             s2_rdy;
    logic [TAG_W-1:0] s2_tag;
    logic [XLEN-1:0]  s2_val;
    logic [TAG_W-1:0] dst_tag;
  } ent_t;

  typedef struct packed {
    logic [7:0]       instr;
    logic [XLEN-1:0]  address;
    logic [XLEN-1:0]  immediate;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [TAG_W-1:0] dst_tag;
  } out_t;

  // Returns {rdy, value}; a waiting operand captures CDB 0 in preference to CDB 1.
  function automatic logic [XLEN:0] f_wake(
    input logic                  rdy,
    input logic [TAG_W-1:0]      tag,
    input logic [XLEN-1:0]       val,
    input logic [1:0]            cv,
    input logic [1:0][TAG_W-1:0] ct,
    input logic [1:0][XLEN-1:0]  cd
  );
    f_wake = {rdy, val};
    if (!rdy) begin
      if (cv[0] && ct[0] == tag)      f_wake = {1'b1, cd[0]};
      else if (cv[1] && ct[1] == tag) f_wake = {1'b1, cd[1]};
    end
  endfunction

  logic [SIZE-1:0]           r_busy;
  ent_t                      r_ent [SIZE];
  out_t                      r_out;
  logic                      r_out_valid;
  logic                      r_overflow;

  logic                      w_f0_ok, w_f1_ok;
  logic [IDX_W-1:0]          w_f0, w_f1;
  logic [CNT_W-1:0]          w_nfree;
  logic [1:0]                w_acc, w_alloc;
  logic [1:0][IDX_W-1:0]     w_tgt;
  logic                      w_ovf;
  logic                      w_sel_ok;
  logic [IDX_W-1:0]          w_sel;
  logic                      w_adv;
  ent_t                      w_new [2];

  // Free search uses registered busy only, so an entry freed this edge is not reused until next cycle.
  always_comb begin
    w_f0_ok = 1'b0;
    w_f1_ok = 1'b0;
    w_f0    = '0;
    w_f1    = '0;
    w_nfree = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (!r_busy[i]) begin
        if (!w_f0_ok) begin
          w_f0_ok = 1'b1;
          w_f0    = IDX_W'(i);
        end else if (!w_f1_ok) begin
          w_f1_ok = 1'b1;
          w_f1    = IDX_W'(i);
        end
        w_nfree = w_nfree + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_acc[0]   = i_in_valid[0] && (i_in_st_type[0] == ST_TYPE);
    w_acc[1]   = i_in_valid[1] && (i_in_st_type[1] == ST_TYPE);
    w_alloc[0] = w_acc[0] && w_f0_ok;
    w_tgt[0]   = w_f0;
    w_alloc[1] = w_acc[1] && (w_acc[0] ? w_f1_ok : w_f0_ok);
    w_tgt[1]   = w_acc[0] ? w_f1 : w_f0;
    w_ovf      = (w_acc[0] && !w_f0_ok) || (w_acc[1] && !w_alloc[1]);
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_new[s].instr     = i_in_instr[s];
      w_new[s].address   = i_in_address[s];
      w_new[s].immediate = i_in_immediate[s];
      w_new[s].s1_tag    = i_in_src1_tag[s];
      w_new[s].s2_tag    = i_in_src2_tag[s];
      w_new[s].dst_tag   = i_in_dst_tag[s];
      {w_new[s].s1_rdy, w_new[s].s1_val} = f_wake(i_in_src1_rdy[s], i_in_src1_tag[s],
                                                  i_in_src1_val[s], i_cdb_valid, i_cdb_tag, i_cdb_data);
      {w_new[s].s2_rdy, w_new[s].s2_val} = f_wake(i_in_src2_rdy[s], i_in_src2_tag[s],
                                                  i_in_src2_val[s], i_cdb_valid, i_cdb_tag, i_cdb_data);
    end
  end

  always_comb begin
    w_sel_ok = 1'b0;
    w_sel    = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (r_busy[i] && r_ent[i].s1_rdy && r_ent[i].s2_rdy) begin
        w_sel_ok = 1'b1;
        w_sel    = IDX_W'(i);
      end
    end
  end

  assign w_adv = !r_out_valid || i_out_ready;

  // Entry payload carries no reset: busy alone qualifies its contents.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (r_busy[i]) begin
        {r_ent[i].s1_rdy, r_ent[i].s1_val} <= f_wake(r_ent[i].s1_rdy, r_ent[i].s1_tag, r_ent[i].s1_val,
                                                     i_cdb_valid, i_cdb_tag, i_cdb_data);
        {r_ent[i].s2_rdy, r_ent[i].s2_val} <= f_wake(r_ent[i].s2_rdy, r_ent[i].s2_tag, r_ent[i].s2_val,
                                                     i_cdb_valid, i_cdb_tag, i_cdb_data);
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (w_alloc[s]) r_ent[w_tgt[s]] <= w_new[s];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_overflow  <= 1'b0;
    end else if (i_flush) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_adv) begin
        r_out_valid <= w_sel_ok;
        if (w_sel_ok) begin
          r_out.instr     <= r_ent[w_sel].instr;
          r_out.address   <= r_ent[w_sel].address;
          r_out.immediate <= r_ent[w_sel].immediate;
          r_out.src1      <= r_ent[w_sel].s1_val;
          r_out.src2      <= r_ent[w_sel].s2_val;
          r_out.dst_tag   <= r_ent[w_sel].dst_tag;
          r_busy[w_sel]   <= 1'b0;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (w_alloc[s]) r_busy[w_tgt[s]] <= 1'b1;
      end
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_out_instr     = r_out.instr;
  assign o_out_address   = r_out.address;
  assign o_out_immediate = r_out.immediate;
  assign o_out_src1      = r_out.src1;
  assign o_out_src2      = r_out.src2;
  assign o_out_dst_tag   = r_out.dst_tag;
  // Four free entries cover a pair in flight from the issuer plus a pair landing on this edge.
  assign o_full          = (w_nfree < CNT_W'(4));
  assign o_overflow      = r_overflow;

endmodule
